// File: rtl/serial_lane_packer_if.sv
// Handshake/bus bundle for serial_lane_packer.
// The serial beat side (I, valid_data_in, ready_data_in) and the packed group side
// (O0..O3, valid_data_out, ready_data_out) travel together.
// With PACKER_LAST_EN defined, last_data_in and lane_count_out are added.
// slave  : the packer's view.
// master : the view of the environment driving beats and consuming groups.
interface serial_lane_packer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] I;
    logic             valid_data_in;
    logic             ready_data_in;
    logic [WIDTH-1:0] O0;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [WIDTH-1:0] O3;
    logic             valid_data_out;
    logic             ready_data_out;
`ifdef PACKER_LAST_EN
    logic             last_data_in;
    logic [2:0]       lane_count_out;

    modport slave (
        input  I, valid_data_in, ready_data_out, last_data_in,
        output ready_data_in, O0, O1, O2, O3, valid_data_out, lane_count_out
    );
    modport master (
        output I, valid_data_in, ready_data_out, last_data_in,
        input  ready_data_in, O0, O1, O2, O3, valid_data_out, lane_count_out
    );
`else
    modport slave (
        input  I, valid_data_in, ready_data_out,
        output ready_data_in, O0, O1, O2, O3, valid_data_out
    );
    modport master (
        output I, valid_data_in, ready_data_out,
        input  ready_data_in, O0, O1, O2, O3, valid_data_out
    );
`endif
endinterface

// File: rtl/serial_lane_packer.sv
// serial_lane_packer: gathers a serial stream of WIDTH-bit beats into groups of four
// and presents each group on O0..O3 (first beat -> O0) with one valid/ready handshake.
// A fill register collects the next group while the output register is held, so up
// to seven beats can be buffered.
// Optional feature macro: PACKER_LAST_EN. It adds last_data_in, which closes a short
// group early and zero-fills the unused lanes. It also adds lane_count_out, which
// reports the number of lanes used.
module serial_lane_packer #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 CE,
    serial_lane_packer_if.slave  bus
);
    logic [1:0]       cnt;
    logic [WIDTH-1:0] fill [3];
    logic [WIDTH-1:0] lane [4];
    logic [WIDTH-1:0] lane_nxt [4];
    logic             out_valid;
    logic             completing;
    logic             ready_in;
    logic             in_fire;
    logic             out_fire;
`ifdef PACKER_LAST_EN
    logic [2:0]       lane_count;
`endif

    // Decide whether the beat on I closes the current group.
    always_comb begin
`ifdef PACKER_LAST_EN
        completing = (cnt == 2'd3) || bus.last_data_in;
`else
        completing = (cnt == 2'd3);
`endif
    end

    // Handshake qualifiers. ready_in depends combinationally on ready_data_out,
    // so a full packer can accept its completing beat in the same cycle the
    // held group leaves.
    always_comb begin
        ready_in = CE && (!completing || !out_valid || bus.ready_data_out);
        in_fire  = CE && bus.valid_data_in && ready_in;
        out_fire = CE && out_valid && bus.ready_data_out;
    end

    // Assemble the group that a completing beat would load.
    // Lanes past the current beat are zero; this only occurs for short groups.
    always_comb begin
        lane_nxt[0] = (cnt == 2'd0) ? bus.I : fill[0];
        lane_nxt[1] = (cnt == 2'd1) ? bus.I : (cnt > 2'd1) ? fill[1] : '0;
        lane_nxt[2] = (cnt == 2'd2) ? bus.I : (cnt == 2'd3) ? fill[2] : '0;
        lane_nxt[3] = (cnt == 2'd3) ? bus.I : '0;
    end

    // Fill side: store non-completing beats and advance the count.
    // The count returns to zero only when a group completes.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt     <= 2'd0;
            fill[0] <= '0;
            fill[1] <= '0;
            fill[2] <= '0;
        end else if (in_fire) begin
            if (completing) begin
                cnt <= 2'd0;
            end else begin
                cnt <= cnt + 2'd1;
                case (cnt)
                    2'd0:    fill[0] <= bus.I;
                    2'd1:    fill[1] <= bus.I;
                    default: fill[2] <= bus.I;
                endcase
            end
        end
    end

    // Output side: a completing beat loads a new group and wins over a
    // simultaneous drain, so there is no bubble. A plain drain only clears valid;
    // the lane values are left holding.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            out_valid  <= 1'b0;
            lane[0]    <= '0;
            lane[1]    <= '0;
            lane[2]    <= '0;
            lane[3]    <= '0;
`ifdef PACKER_LAST_EN
            lane_count <= 3'd0;
`endif
        end else if (in_fire && completing) begin
            out_valid  <= 1'b1;
            lane[0]    <= lane_nxt[0];
            lane[1]    <= lane_nxt[1];
            lane[2]    <= lane_nxt[2];
            lane[3]    <= lane_nxt[3];
`ifdef PACKER_LAST_EN
            lane_count <= {1'b0, cnt} + 3'd1;
`endif
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.ready_data_in  = ready_in;
    assign bus.valid_data_out = out_valid;
    assign bus.O0             = lane[0];
    assign bus.O1             = lane[1];
    assign bus.O2             = lane[2];
    assign bus.O3             = lane[3];
`ifdef PACKER_LAST_EN
    assign bus.lane_count_out = lane_count;
`endif
endmodule

// File: tb/tb_serial_lane_packer.sv
// Self-checking bench for serial_lane_packer.
// Directed scenarios are followed by a randomized phase. A queue-based reference
// model predicts acceptance and the groups; a negedge monitor compares the DUT
// against that model every cycle.
module tb_serial_lane_packer;
    typedef struct packed {
        logic [3:0][7:0] l;
        logic [2:0]      n;
    } grp_t;

    logic CLK;
    logic RESETN;
    logic CE;
    logic last_in;

    serial_lane_packer_if #(.WIDTH(8)) bus ();

    serial_lane_packer #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CE     (CE),
        .bus    (bus.slave)
    );

`ifdef PACKER_LAST_EN
    assign bus.last_data_in = last_in;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] partial [$];
    grp_t       exp_q   [$];
    grp_t       last_grp;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge CLK) begin
        logic exp_rdy;
        logic [3:0][7:0] act_l;
        grp_t g;
        act_l = {bus.O3, bus.O2, bus.O1, bus.O0};
        if (!RESETN) begin
            partial.delete();
            exp_q.delete();
            last_grp = '0;
            chk("reset_valid", {31'd0, bus.valid_data_out}, 32'd0);
            chk("reset_lanes", act_l, 32'd0);
            chk("reset_ready", {31'd0, bus.ready_data_in}, {31'd0, CE});
        end else begin
            exp_rdy = CE && (!(partial.size() == 3 || last_in) || exp_q.size() == 0 ||
                             bus.ready_data_out);
            chk("ready_in", {31'd0, bus.ready_data_in}, {31'd0, exp_rdy});
            chk("valid_out", {31'd0, bus.valid_data_out}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("lanes", act_l, exp_q[0].l);
`ifdef PACKER_LAST_EN
                chk("lane_count", {29'd0, bus.lane_count_out}, {29'd0, exp_q[0].n});
`endif
            end else begin
                chk("lanes_hold", act_l, last_grp.l);
            end
            if (CE && bus.ready_data_out && exp_q.size() != 0)
                last_grp = exp_q.pop_front();
            if (CE && bus.valid_data_in && exp_rdy) begin
                partial.push_back(bus.I);
                if (partial.size() == 4 || last_in) begin
                    g = '0;
                    for (int i = 0; i < partial.size(); i++) g.l[i] = partial[i];
                    g.n = 3'(partial.size());
                    exp_q.push_back(g);
                    partial.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer one beat until the DUT takes it, bounded.
    task automatic send(input logic [7:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        bus.I = d;
        bus.valid_data_in = 1'b1;
        last_in = l;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge CLK);
            acc = bus.ready_data_in;
            step();
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
        end
        bus.valid_data_in = 1'b0;
        last_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN = 1'b0;
        CE = 1'b1;
        last_in = 1'b0;
        bus.I = '0;
        bus.valid_data_in = 1'b0;
        bus.ready_data_out = 1'b0;
        // Reset held: lanes zero, ready follows CE
        step(); step();
        CE = 1'b0;
        step(); step();
        CE = 1'b1;
        step();
        RESETN = 1'b1;
        step();

        // Back-to-back groups with a ready downstream
        bus.ready_data_out = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
        step(); step();

        // Downstream stall: fill buffer, completing beat waits for drain
        bus.ready_data_out = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h20 + 8'(i), 1'b0);
        bus.I = 8'h27;
        bus.valid_data_in = 1'b1;
        step(); step(); step();
        bus.ready_data_out = 1'b1;
        step();
        bus.valid_data_in = 1'b0;
        step(); step();

        // Clock enable low freezes everything
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        CE = 1'b0;
        bus.I = 8'hA2;
        bus.valid_data_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        CE = 1'b1;
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        step(); step();

        // Mid-group reset discards the partial group
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send(8'h05 + 8'(i), 1'b0);
        step(); step();

`ifdef PACKER_LAST_EN
        // Short group closed by last, then a full group
        send(8'h31, 1'b0);
        send(8'h32, 1'b1);
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0);
        send(8'h55, 1'b1);
        step(); step();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            CE = ($urandom_range(0, 9) != 0);
            bus.valid_data_in = ($urandom_range(0, 9) < 7);
            bus.I = 8'($urandom);
            bus.ready_data_out = ($urandom_range(0, 9) < 6);
`ifdef PACKER_LAST_EN
            last_in = ($urandom_range(0, 9) < 2);
`endif
            step();
        end

        // Drain
        CE = 1'b1;
        bus.valid_data_in = 1'b0;
        last_in = 1'b0;
        bus.ready_data_out = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("groups_left", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
